// File: rtl/raw_pair_sequencer.sv
// raw_pair_sequencer: buffers one even Bayer raw line, then pairs each word of
// the following odd line with the buffered word at the same column.
//
// Ports:
//   CLK, RST                   clock, asynchronous active-high reset
//   S_DATA/S_VALID/S_READY     raw word input stream with handshake
//   S_SOF, S_EOL               first word of frame / last word of line markers
//   M_DATA_IN1                 buffered even-line word (registered)
//   M_DATA_IN2                 live odd-line word (registered)
//   M_VALID/M_READY            output pair handshake
//   M_SOF, M_EOL               first pair of frame / last pair of line pair
//   ERR_LEN                    one-cycle pulse on a line-length error
//   PAIR_CNT                   line pairs completed in the current frame
module raw_pair_sequencer #(
    parameter int unsigned DATA_WIDTH_RAW = 16,
    parameter int unsigned MAX_LINE_WORDS = 1024,
    parameter int unsigned ADDR_WIDTH     = 10
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH_RAW-1:0] S_DATA,
    input  logic                      S_VALID,
    output logic                      S_READY,
    input  logic                      S_SOF,
    input  logic                      S_EOL,
    output logic [DATA_WIDTH_RAW-1:0] M_DATA_IN1,
    output logic [DATA_WIDTH_RAW-1:0] M_DATA_IN2,
    output logic                      M_VALID,
    input  logic                      M_READY,
    output logic                      M_SOF,
    output logic                      M_EOL,
    output logic                      ERR_LEN,
    output logic [15:0]               PAIR_CNT
);

    // Pointers carry one extra bit so they can hold MAX_LINE_WORDS itself.
    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] MAX_PTR = PW'(MAX_LINE_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAIR
    } state_t;

    state_t                    state, state_d;
    logic [PW-1:0]             wr_ptr, wr_ptr_d;
    logic [PW-1:0]             rd_ptr, rd_ptr_d;
    logic [PW-1:0]             fill_len, fill_len_d;
    logic                      ovf, ovf_d;
    logic                      sof_pend, sof_pend_d;
    logic [DATA_WIDTH_RAW-1:0] m_data1, m_data1_d;
    logic [DATA_WIDTH_RAW-1:0] m_data2, m_data2_d;
    logic                      m_valid, m_valid_d;
    logic                      m_sof, m_sof_d;
    logic                      m_eol, m_eol_d;
    logic                      err_len, err_len_d;
    logic [15:0]               pair_cnt, pair_cnt_d;

    logic                      wr_en;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH_RAW-1:0] rd_word;
    logic                      accept;
    logic                      last;

    logic [DATA_WIDTH_RAW-1:0] mem [MAX_LINE_WORDS];

    assign M_DATA_IN1 = m_data1;
    assign M_DATA_IN2 = m_data2;
    assign M_VALID    = m_valid;
    assign M_SOF      = m_sof;
    assign M_EOL      = m_eol;
    assign ERR_LEN    = err_len;
    assign PAIR_CNT   = pair_cnt;

    // Line buffer: synchronous write, asynchronous read; contents are not reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= S_DATA;
        end
    end

    assign rd_word = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_len <= '0;
            ovf      <= 1'b0;
            sof_pend <= 1'b0;
            m_data1  <= '0;
            m_data2  <= '0;
            m_valid  <= 1'b0;
            m_sof    <= 1'b0;
            m_eol    <= 1'b0;
            err_len  <= 1'b0;
            pair_cnt <= '0;
        end else begin
            state    <= state_d;
            wr_ptr   <= wr_ptr_d;
            rd_ptr   <= rd_ptr_d;
            fill_len <= fill_len_d;
            ovf      <= ovf_d;
            sof_pend <= sof_pend_d;
            m_data1  <= m_data1_d;
            m_data2  <= m_data2_d;
            m_valid  <= m_valid_d;
            m_sof    <= m_sof_d;
            m_eol    <= m_eol_d;
            err_len  <= err_len_d;
            pair_cnt <= pair_cnt_d;
        end
    end

    // Next-state, buffer write and output register loads.
    always_comb begin
        state_d    = state;
        wr_ptr_d   = wr_ptr;
        rd_ptr_d   = rd_ptr;
        fill_len_d = fill_len;
        ovf_d      = ovf;
        sof_pend_d = sof_pend;
        m_data1_d  = m_data1;
        m_data2_d  = m_data2;
        m_valid_d  = m_valid;
        m_sof_d    = m_sof;
        m_eol_d    = m_eol;
        err_len_d  = 1'b0;
        pair_cnt_d = pair_cnt;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr[ADDR_WIDTH-1:0];

        S_READY = (state == ST_PAIR) ? (!m_valid || M_READY) : 1'b1;
        accept  = S_VALID && S_READY;
        last    = (rd_ptr == fill_len - PW'(1));

        // Pair handed downstream; a load below may refill it in the same cycle.
        if (m_valid && M_READY) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            if (S_SOF) begin
                // New frame: restart from address 0 regardless of state.
                if (state == ST_PAIR) begin
                    err_len_d = 1'b1;
                end
                wr_en      = 1'b1;
                wr_addr    = '0;
                wr_ptr_d   = PW'(1);
                rd_ptr_d   = '0;
                ovf_d      = 1'b0;
                sof_pend_d = 1'b1;
                pair_cnt_d = '0;
                if (S_EOL) begin
                    fill_len_d = PW'(1);
                    state_d    = ST_PAIR;
                end else begin
                    state_d    = ST_FILL;
                end
            end else begin
                unique case (state)
                    ST_FILL: begin
                        if (wr_ptr == MAX_PTR) begin
                            // Line too long: drop the word, flag only the first excess.
                            if (!ovf) begin
                                err_len_d = 1'b1;
                                ovf_d     = 1'b1;
                            end
                        end else begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr + PW'(1);
                        end
                        if (S_EOL) begin
                            fill_len_d = (wr_ptr == MAX_PTR) ? MAX_PTR : wr_ptr + PW'(1);
                            rd_ptr_d   = '0;
                            ovf_d      = 1'b0;
                            state_d    = ST_PAIR;
                        end
                    end
                    ST_PAIR: begin
                        m_data1_d  = rd_word;
                        m_data2_d  = S_DATA;
                        m_valid_d  = 1'b1;
                        m_sof_d    = sof_pend;
                        sof_pend_d = 1'b0;
                        rd_ptr_d   = rd_ptr + PW'(1);
                        if (last || S_EOL) begin
                            // End of line pair; an early S_EOL is a short odd line.
                            m_eol_d    = 1'b1;
                            state_d    = ST_FILL;
                            wr_ptr_d   = '0;
                            pair_cnt_d = pair_cnt + 16'd1;
                            if (!last) begin
                                err_len_d = 1'b1;
                            end
                        end else begin
                            m_eol_d = 1'b0;
                        end
                    end
                    default: begin
                        // IDLE: words outside a frame are discarded.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_raw_pair_sequencer.sv
// Directed bench for raw_pair_sequencer with MAX_LINE_WORDS=4. Stimulus pushes
// expected pairs into a queue; a monitor pops and compares on every accepted pair.
module tb_raw_pair_sequencer;

    typedef struct packed {
        logic [15:0] d1;
        logic [15:0] d2;
        logic        sof;
        logic        eol;
    } pair_t;

    logic        clk;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_sof;
    logic        s_eol;
    logic [15:0] m_data_in1;
    logic [15:0] m_data_in2;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_eol;
    logic        err_len;
    logic [15:0] pair_cnt;

    int    total = 0;
    int    bad = 0;
    int    err_seen = 0;
    int    err_base = 0;
    bit    stall_en = 0;
    bit    stall_done = 0;
    pair_t exp_q[$];

    raw_pair_sequencer #(
        .DATA_WIDTH_RAW(16),
        .MAX_LINE_WORDS(4),
        .ADDR_WIDTH(2)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .S_DATA(s_data),
        .S_VALID(s_valid),
        .S_READY(s_ready),
        .S_SOF(s_sof),
        .S_EOL(s_eol),
        .M_DATA_IN1(m_data_in1),
        .M_DATA_IN2(m_data_in2),
        .M_VALID(m_valid),
        .M_READY(m_ready),
        .M_SOF(m_sof),
        .M_EOL(m_eol),
        .ERR_LEN(err_len),
        .PAIR_CNT(pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called at a negedge; holds the word until accepted.
    task automatic send(input logic [15:0] d, input logic sof, input logic eol);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eol   = eol;
        #2;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!s_ready) chk("send_timeout", 36'd0, 36'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic expect_pair(input logic [15:0] d1, input logic [15:0] d2,
                               input logic sof, input logic eol);
        pair_t p;
        p.d1 = d1; p.d2 = d2; p.sof = sof; p.eol = eol;
        exp_q.push_back(p);
    endtask

    task automatic settle(input string name, input logic [15:0] cnt, input int errs);
        repeat (4) @(negedge clk);
        #2;
        chk({name, "_pair_cnt"}, 36'(pair_cnt), 36'(cnt));
        chk({name, "_err_pulses"}, 36'(err_seen - err_base), 36'(errs));
        chk({name, "_queue_drained"}, 36'(exp_q.size()), 36'd0);
        err_base = err_seen;
    endtask

    // Monitor: pops one expected pair per accepted output, checks hold stability.
    initial begin
        pair_t held_val;
        pair_t got;
        pair_t e;
        bit    held = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                held = 0;
            end else begin
                got = {m_data_in1, m_data_in2, m_sof, m_eol};
                if (held) chk("hold_stable", 36'(got), 36'(held_val));
                held     = m_valid && !m_ready;
                held_val = got;
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pair", 36'(got), 36'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pair", 36'(got), 36'(e));
                    end
                end
                if (err_len) err_seen++;
            end
        end
    end

    // Backpressure: hold M_READY low for 3 cycles when pair 2 appears.
    initial begin
        forever begin
            @(negedge clk);
            if (stall_en && !stall_done && m_valid && m_data_in2 == 16'hA2A2) begin
                m_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #2;
                    chk("stall_s_ready", 36'(s_ready), 36'd0);
                    @(negedge clk);
                end
                m_ready    = 1'b1;
                stall_done = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b1;
        #12;
        chk("reset_outputs", 36'({m_valid, m_sof, m_eol, err_len}), 36'd0);
        chk("reset_data", 36'({m_data_in1, m_data_in2}), 36'd0);
        chk("reset_pair_cnt", 36'(pair_cnt), 36'd0);
        chk("reset_s_ready", 36'(s_ready), 36'd1);
        @(negedge clk);
        rst = 1'b0;

        // Basic pair.
        expect_pair(16'h0101, 16'hA1A1, 1, 0);
        expect_pair(16'h0202, 16'hA2A2, 0, 0);
        expect_pair(16'h0303, 16'hA3A3, 0, 0);
        expect_pair(16'h0404, 16'hA4A4, 0, 1);
        send(16'h0101, 1, 0); send(16'h0202, 0, 0); send(16'h0303, 0, 0); send(16'h0404, 0, 1);
        send(16'hA1A1, 0, 0); send(16'hA2A2, 0, 0); send(16'hA3A3, 0, 0); send(16'hA4A4, 0, 1);
        settle("basic", 16'd1, 0);

        // Backpressure on pair 2.
        stall_en = 1'b1;
        expect_pair(16'h0101, 16'hA1A1, 1, 0);
        expect_pair(16'h0202, 16'hA2A2, 0, 0);
        expect_pair(16'h0303, 16'hA3A3, 0, 0);
        expect_pair(16'h0404, 16'hA4A4, 0, 1);
        send(16'h0101, 1, 0); send(16'h0202, 0, 0); send(16'h0303, 0, 0); send(16'h0404, 0, 1);
        send(16'hA1A1, 0, 0); send(16'hA2A2, 0, 0); send(16'hA3A3, 0, 0); send(16'hA4A4, 0, 1);
        settle("backpressure", 16'd1, 0);
        chk("stall_happened", 36'(stall_done), 36'd1);
        stall_en = 1'b0;

        // Short odd line, then a normal 2-word line pair in FILL.
        expect_pair(16'h1111, 16'hB1B1, 1, 0);
        expect_pair(16'h2222, 16'hB2B2, 0, 1);
        send(16'h1111, 1, 0); send(16'h2222, 0, 0); send(16'h3333, 0, 0); send(16'h4444, 0, 1);
        send(16'hB1B1, 0, 0); send(16'hB2B2, 0, 1);
        settle("short_odd", 16'd1, 1);
        expect_pair(16'h5151, 16'hC1C1, 0, 0);
        expect_pair(16'h5252, 16'hC2C2, 0, 1);
        send(16'h5151, 0, 0); send(16'h5252, 0, 1);
        send(16'hC1C1, 0, 0); send(16'hC2C2, 0, 1);
        settle("after_short", 16'd2, 0);

        // Overflow: 6-word even line truncated to 4.
        expect_pair(16'h0011, 16'hD1D1, 1, 0);
        expect_pair(16'h0022, 16'hD2D2, 0, 0);
        expect_pair(16'h0033, 16'hD3D3, 0, 0);
        expect_pair(16'h0044, 16'hD4D4, 0, 1);
        send(16'h0011, 1, 0); send(16'h0022, 0, 0); send(16'h0033, 0, 0);
        send(16'h0044, 0, 0); send(16'h0055, 0, 0); send(16'h0066, 0, 1);
        send(16'hD1D1, 0, 0); send(16'hD2D2, 0, 0); send(16'hD3D3, 0, 0); send(16'hD4D4, 0, 1);
        settle("overflow", 16'd1, 1);

        // Resync: S_SOF arrives during the second line pair's odd line.
        expect_pair(16'h0A0A, 16'hE1E1, 1, 0);
        expect_pair(16'h0B0B, 16'hE2E2, 0, 1);
        expect_pair(16'h0C0C, 16'hF1F1, 0, 0);
        send(16'h0A0A, 1, 0); send(16'h0B0B, 0, 1);
        send(16'hE1E1, 0, 0); send(16'hE2E2, 0, 1);
        send(16'h0C0C, 0, 0); send(16'h0D0D, 0, 1);
        send(16'hF1F1, 0, 0);
        #2;
        chk("resync_cnt_before", 36'(pair_cnt), 36'd1);
        @(negedge clk);
        send(16'h0F0F, 1, 0);
        #2;
        chk("resync_cnt_after", 36'(pair_cnt), 36'd0);
        @(negedge clk);
        expect_pair(16'h0F0F, 16'h9191, 1, 0);
        expect_pair(16'h1F1F, 16'h9292, 0, 1);
        send(16'h1F1F, 0, 1);
        send(16'h9191, 0, 0); send(16'h9292, 0, 1);
        settle("resync", 16'd1, 1);

        // Asynchronous reset mid-PAIR.
        expect_pair(16'h3333, 16'h5555, 1, 0);
        send(16'h3333, 1, 0); send(16'h4444, 0, 1);
        send(16'h5555, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", 36'({m_valid, m_sof, m_eol, err_len}), 36'd0);
        chk("async_rst_data", 36'({m_data_in1, m_data_in2}), 36'd0);
        chk("async_rst_pair_cnt", 36'(pair_cnt), 36'd0);
        @(negedge clk);
        rst = 1'b0;
        err_base = err_seen;
        send(16'h7777, 0, 0); send(16'h8888, 0, 1); send(16'h6666, 0, 0); send(16'h6767, 0, 1);
        settle("post_rst_drop", 16'd0, 0);
        expect_pair(16'h1234, 16'h4321, 1, 1);
        send(16'h1234, 1, 1);
        send(16'h4321, 0, 1);
        settle("one_word_line", 16'd1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
